// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } kscan_state_t;

  localparam logic [3:0] KEY_NONE = 4'd13;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Scanner-side and CPU-side signals of the keypad scan controller.
// The controller is the slave; the scanner/CPU environment is the master.
interface keypad_scan_ctrl_if;

  logic       key_press;
  logic [3:0] key_data;
  logic       scan_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       intr;
  logic       overrun;

  modport master (
    output key_press, key_data, key_ack,
    input  scan_en, key_code, key_valid, intr, overrun
  );

  modport slave (
    input  key_press, key_data, key_ack,
    output scan_en, key_code, key_valid, intr, overrun
  );

endinterface

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// Free-running divider: registered one-cycle tick every SCAN_DIV clocks,
// high in the cycle the counter sits at SCAN_DIV-1.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned     CntW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(SCAN_DIV - 2);

  logic [CntW-1:0] r_cnt;
  logic            r_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CntLast) ? '0 : r_cnt + 1'b1;
      // Registered one cycle early so the tick lines up with CntLast.
      r_tick <= (r_cnt == CntPre);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: tick generation, press/release debounce and VALID/ACK key latch.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEBOUNCE    = 8,
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_RATE = 100
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  keypad_scan_ctrl_if.slave   io_kp
);

  localparam int unsigned    DbW    = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE);
  localparam logic [DbW-1:0] DbOne  = DbW'(1);

  kscan_state_t   r_state;
  logic [3:0]     r_cand;
  logic [DbW-1:0] r_cnt;
  logic [3:0]     r_code;
  logic           r_valid;
  logic           r_intr;
  logic           r_overrun;

  logic           w_tick;
  logic           w_match;
  logic           w_db_done;
  logic [DbW-1:0] w_cnt_inc;
  logic           w_accept_db;
  logic           w_accept_rep;
  logic           w_accept;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  assign w_match     = io_kp.key_press && (io_kp.key_data == r_cand);
  assign w_db_done   = (r_cnt >= DbLast);
  assign w_cnt_inc   = (r_cnt == DbMax) ? r_cnt : r_cnt + 1'b1;
  assign w_accept_db = w_tick && (r_state == S_DEBOUNCE) && w_match && w_db_done;
  assign w_accept    = w_accept_db || w_accept_rep;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned    RepMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned    RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepSat = RepW'(RepMax);

  logic [RepW-1:0] r_rep_cnt;
  logic            r_rep_first;
  logic [RepW-1:0] w_rep_next;
  logic [RepW-1:0] w_rep_limit;

  assign w_rep_next   = (r_rep_cnt == RepSat) ? r_rep_cnt : r_rep_cnt + 1'b1;
  assign w_rep_limit  = r_rep_first ? RepW'(REPEAT_RATE) : RepW'(REPEAT_DLY);
  assign w_accept_rep = w_tick && (r_state == S_HELD) && io_kp.key_press &&
                        (w_rep_next >= w_rep_limit);

  // Counts ticks since the last accept; zero whenever the key is not held.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (r_state != S_HELD)) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (w_tick) begin
      if (!io_kp.key_press) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else if (w_accept_rep) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end else begin
        r_rep_cnt   <= w_rep_next;
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REPEAT_DLY, REPEAT_RATE};
  assign w_accept_rep = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cand    <= KEY_NONE;
      r_cnt     <= '0;
      r_code    <= KEY_NONE;
      r_valid   <= 1'b0;
      r_intr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (io_kp.key_press) begin
              r_cand  <= io_kp.key_data;
              r_cnt   <= DbOne;
              r_state <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (!w_match) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_db_done) r_state <= S_HELD;
            end
          end
          S_HELD: begin
            if (!io_kp.key_press) begin
              r_cnt   <= DbOne;
              r_state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (io_kp.key_press) begin
              r_state <= S_HELD;
            end else if (w_db_done) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // An ACK coinciding with an accept hands the slot straight to the new key.
      r_intr <= 1'b0;
      if (w_accept) begin
        if (!r_valid || io_kp.key_ack) begin
          r_code    <= r_cand;
          r_valid   <= 1'b1;
          r_intr    <= 1'b1;
          r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (io_kp.key_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign io_kp.scan_en   = w_tick;
  assign io_kp.key_code  = r_code;
  assign io_kp.key_valid = r_valid;
  assign io_kp.intr      = r_intr;
  assign io_kp.overrun   = r_overrun;

endmodule
